wave_phase_driver: RTL and testbench

Sample-rate oscillator core that drives the wavetable lookup from the read side. It divides the system clock down to the audio sample rate and advances a phase accumulator by a tuning word on each sample tick. It presents the accumulator's top 8 bits as the wavetable address, captures the returned 8-bit sample, and hands it downstream (DAC/mixer) over a valid/ready handshake. It sits between the note/pot control logic and the combinational wavetable, and owns all sequencing the table lacks.

---
 rtl/wave_phase_driver.sv | 134 +++++++++++++
 tb/tb_wave_phase_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_phase_driver.sv
// wave_phase_driver: sample-rate phase accumulator that drives a combinational wavetable.
// It captures the returned sample and offers it downstream over a valid/ready handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a sample tick; phase and wave_out hold
//   S_LOOKUP | new addr/wave_out presented; table_y captured at cycle end
//
module wave_phase_driver #(
  parameter int CLK_DIV = 1000,
  parameter int PHASE_W = 24
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_sync,
  input  logic [PHASE_W-1:0] i_tune,
  input  logic [3:0]         i_wave_sel,
  output logic [7:0]         o_addr,
  output logic [3:0]         o_wave_out,
  input  logic [7:0]         i_table_y,
  output logic [7:0]         o_sample,
  output logic               o_sample_valid,
  input  logic               i_sample_ready,
  output logic               o_overrun,
  input  logic               i_overrun_clr
);

  localparam int CNT_W = $clog2(CLK_DIV);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOOKUP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [3:0]         r_wave;
  logic [3:0]         w_wave_nxt;
  logic [7:0]         r_sample;
  logic               r_valid;
  logic               r_overrun;
  logic               w_tick;
  logic               w_capture;
  logic               w_accept;

  assign w_tick   = (r_count == CNT_W'(CLK_DIV - 1));
  assign w_accept = r_valid & i_sample_ready;

  // Free-running sample-rate divider; sync restarts the sample period.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_sync || w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // FSM state, phase accumulator and latched waveform select.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_wave  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_wave  <= w_wave_nxt;
    end
  end

  // Next-state logic; sync overrides everything and aborts a pending lookup.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_wave_nxt  = r_wave;
    w_capture   = 1'b0;
    if (i_sync) begin
      w_state_nxt = S_IDLE;
      w_phase_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick && i_en) begin
            w_phase_nxt = r_phase + i_tune;
            w_wave_nxt  = i_wave_sel;
            w_state_nxt = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Output sample register with valid/ready handshake and sticky overrun.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sample  <= 8'h80;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sample <= i_table_y;
        r_valid  <= 1'b1;
      end else if (w_accept) begin
        r_valid  <= 1'b0;
      end
      // Set takes priority over clear so an overwrite is never lost.
      if (w_capture && r_valid && !i_sample_ready) begin
        r_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_addr         = r_phase[PHASE_W-1 -: 8];
  assign o_wave_out     = r_wave;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_wave_phase_driver.sv
// Directed bench for wave_phase_driver with CLK_DIV=4: phase/addr model plus sample scoreboard.
module tb_wave_phase_driver;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_en = 1'b0;
  logic        i_sync = 1'b0;
  logic [23:0] i_tune = '0;
  logic [3:0]  i_wave_sel = '0;
  logic [7:0]  o_addr;
  logic [3:0]  o_wave_out;
  logic [7:0]  i_table_y;
  logic [7:0]  o_sample;
  logic        o_sample_valid;
  logic        i_sample_ready = 1'b0;
  logic        o_overrun;
  logic        i_overrun_clr = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_edge  = 0;
  int tick_ofs = 0;

  logic [23:0] m_phase = '0;
  logic [3:0]  m_wave  = '0;
  logic [7:0]  q_exp[$];
  logic [7:0]  junk;

  wave_phase_driver #(.CLK_DIV(4), .PHASE_W(24)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_en           (i_en),
    .i_sync         (i_sync),
    .i_tune         (i_tune),
    .i_wave_sel     (i_wave_sel),
    .o_addr         (o_addr),
    .o_wave_out     (o_wave_out),
    .i_table_y      (i_table_y),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .i_sample_ready (i_sample_ready),
    .o_overrun      (o_overrun),
    .i_overrun_clr  (i_overrun_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tbl(input logic [7:0] a, input logic [3:0] w);
    return (a * 8'd3) ^ {w, w} ^ 8'h5A;
  endfunction

  // Combinational wavetable stand-in.
  assign i_table_y = tbl(o_addr, o_wave_out);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_edge++;
    end
  endtask

  // Advance to the next tick edge, update the model and check addr/wave_out.
  task automatic do_period();
    do step(); while (((n_edge - tick_ofs) % 4) != 0);
    if (i_en) begin
      m_phase = m_phase + i_tune;
      m_wave  = i_wave_sel;
      q_exp.push_back(tbl(m_phase[23:16], m_wave));
    end
    chk("addr", o_addr, m_phase[23:16]);
    chk("wave_out", {4'h0, o_wave_out}, {4'h0, m_wave});
  endtask

  // Scoreboard: a transfer happens on the coming edge; compare the sample being handed over.
  always @(negedge clk) begin
    if (!i_reset && o_sample_valid && i_sample_ready) begin
      if (q_exp.size() == 0) begin
        n_total++;
        n_fail++;
        $error("FAIL unexpected_xfer: observed sample %h with nothing expected", o_sample);
      end else begin
        chk("sample_xfer", o_sample, q_exp.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    step(2);
    chk("rst_addr", o_addr, 8'h00);
    chk("rst_wave", {4'h0, o_wave_out}, 8'h00);
    chk("rst_sample", o_sample, 8'h80);
    chk("rst_valid", {7'h0, o_sample_valid}, 8'h00);
    chk("rst_overrun", {7'h0, o_overrun}, 8'h00);
    i_reset = 1'b0;
    n_edge = 0;
    tick_ofs = 0;

    // Basic stepping, latency of 2 edges from the tick cycle
    i_en = 1'b1;
    i_tune = 24'h010000;
    i_wave_sel = 4'h3;
    i_sample_ready = 1'b1;
    do_period();
    step(1);
    chk("valid_pulse_on", {7'h0, o_sample_valid}, 8'h01);
    step(1);
    chk("valid_pulse_off", {7'h0, o_sample_valid}, 8'h00);
    do_period();
    do_period();

    // Phase wrap FF -> 00
    i_tune = 24'hFC0000;
    do_period();
    i_tune = 24'h010000;
    do_period();
    do_period();
    step(2);

    // Overwrite while not ready -> sticky overrun, then clear
    i_sample_ready = 1'b0;
    do_period();
    step(1);
    chk("valid_held", {7'h0, o_sample_valid}, 8'h01);
    chk("no_overrun_yet", {7'h0, o_overrun}, 8'h00);
    do_period();
    junk = q_exp.pop_front();
    step(1);
    chk("overrun_set", {7'h0, o_overrun}, 8'h01);
    chk("valid_after_ovw", {7'h0, o_sample_valid}, 8'h01);
    step(1);
    chk("overrun_sticky", {7'h0, o_overrun}, 8'h01);
    i_overrun_clr = 1'b1;
    step(1);
    i_overrun_clr = 1'b0;
    chk("overrun_clr", {7'h0, o_overrun}, 8'h00);

    // Capture coinciding with accept
    i_sample_ready = 1'b1;
    do_period();
    i_sample_ready = 1'b0;
    step(1);
    do_period();
    i_sample_ready = 1'b1;
    step(1);
    chk("cap_acc_valid", {7'h0, o_sample_valid}, 8'h01);
    chk("cap_acc_overrun", {7'h0, o_overrun}, 8'h00);
    step(1);
    chk("cap_acc_drained", {7'h0, o_sample_valid}, 8'h00);

    // wave_sel change mid-period only lands at the tick edge
    i_wave_sel = 4'b0100;
    step(1);
    chk("wave_mid_hold", {4'h0, o_wave_out}, {4'h0, m_wave});
    do_period();
    step(2);

    // en low over a tick: hold, no sample
    i_en = 1'b0;
    i_wave_sel = 4'h5;
    do_period();
    step(1);
    chk("en0_no_valid", {7'h0, o_sample_valid}, 8'h00);
    step(1);
    chk("en0_no_valid2", {7'h0, o_sample_valid}, 8'h00);
    i_en = 1'b1;

    // sync during LOOKUP aborts the capture and restarts the period
    do_period();
    i_sync = 1'b1;
    step(1);
    i_sync = 1'b0;
    junk = q_exp.pop_front();
    m_phase = '0;
    tick_ofs = n_edge;
    chk("sync_addr", o_addr, 8'h00);
    chk("sync_no_valid", {7'h0, o_sample_valid}, 8'h00);
    i_tune = 24'h2A0000;
    step(3);
    chk("sync_addr_hold", o_addr, 8'h00);
    chk("sync_no_capture", {7'h0, o_sample_valid}, 8'h00);
    do_period();
    step(2);

    // Async reset mid-LOOKUP
    do_period();
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_sample", o_sample, 8'h80);
    chk("arst_valid", {7'h0, o_sample_valid}, 8'h00);
    chk("arst_overrun", {7'h0, o_overrun}, 8'h00);
    chk("arst_addr", o_addr, 8'h00);
    chk("arst_wave", {4'h0, o_wave_out}, 8'h00);
    junk = q_exp.pop_front();
    m_phase = '0;
    m_wave = '0;
    step(2);
    i_reset = 1'b0;
    tick_ofs = n_edge;
    i_tune = 24'h010000;
    do_period();
    do_period();
    step(2);
    chk("queue_empty", 8'(q_exp.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
